// File: rtl/fp_accum_bank_if.sv
// rtl/fp_accum_bank_if.sv - operand/result handshake bundle for the FP accumulator bank
interface fp_accum_bank_if #(
    parameter int W  = 18,
    parameter int CW = 2
);
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_chan;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_chan;
    logic [W-1:0]  out_data;

    modport master (
        output in_valid, in_chan, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_chan, out_data
    );

    modport slave (
        input  in_valid, in_chan, in_data, in_last, out_ready,
        output in_ready, out_valid, out_chan, out_data
    );
endinterface

// File: rtl/fp_accum_bank.sv
// rtl/fp_accum_bank.sv - multi-channel FloPoCo floating-point accumulator with pipelined adder
module fp_accum_bank #(
    parameter int BITWIDTH = 16,
    parameter int CHANNELS = 4,
    parameter int ADD_LAT  = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    fp_accum_bank_if.slave bus
);
    // FloPoCo word: {exc[1:0], sign, exponent[EW-1:0], fraction[FW-1:0]}
    // exc: 00 zero, 01 normal, 10 infinity, 11 NaN. No subnormals.
    localparam int W  = BITWIDTH + 2;
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int EW = (BITWIDTH <= 16) ? 5 : (BITWIDTH <= 32) ? 8 : 11;
    localparam int FW = BITWIDTH - 1 - EW;
    localparam int M  = FW + 4;   // hidden bit, fraction, guard, round, sticky
    localparam int L  = ADD_LAT;

    // Combinational FPADD_WRAPPER: round-to-nearest-even, flush underflow to zero
    function automatic logic [W-1:0] fp_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [1:0]    xa, xb;
        logic          swap, sr, st, rnd;
        logic [W-1:0]  big, sml, r;
        logic [EW-1:0] ea, eb, d;
        logic [M-1:0]  ma, mb, mask, n;
        logic [M:0]    s;
        logic [FW:0]   fr;
        int            lz, e;
        xa = a[W-1:W-2];
        xb = b[W-1:W-2];
        r  = '0;
        if (xa == 2'b11 || xb == 2'b11 ||
            (xa == 2'b10 && xb == 2'b10 && a[BITWIDTH-1] != b[BITWIDTH-1])) begin
            r = {2'b11, {BITWIDTH{1'b0}}};
        end else if (xa == 2'b10) begin
            r = {2'b10, a[BITWIDTH-1], {(BITWIDTH-1){1'b0}}};
        end else if (xb == 2'b10) begin
            r = {2'b10, b[BITWIDTH-1], {(BITWIDTH-1){1'b0}}};
        end else if (xa == 2'b00) begin
            r = b;
        end else if (xb == 2'b00) begin
            r = a;
        end else begin
            // Order by magnitude so the subtraction never borrows
            swap = (b[BITWIDTH-2:0] > a[BITWIDTH-2:0]);
            big  = swap ? b : a;
            sml  = swap ? a : b;
            sr   = big[BITWIDTH-1];
            ea   = big[BITWIDTH-2:FW];
            eb   = sml[BITWIDTH-2:FW];
            ma   = {1'b1, big[FW-1:0], 3'b000};
            mb   = {1'b1, sml[FW-1:0], 3'b000};
            d    = ea - eb;
            if (int'(d) >= M) begin
                st = 1'b1;
                mb = '0;
            end else begin
                mask = ~({M{1'b1}} << d);
                st   = |(mb & mask);
                mb   = mb >> d;
            end
            mb[0] = mb[0] | st;
            if (big[BITWIDTH-1] == sml[BITWIDTH-1])
                s = {1'b0, ma} + {1'b0, mb};
            else
                s = {1'b0, ma} - {1'b0, mb};
            e = int'(ea);
            if (s != '0) begin
                if (s[M]) begin
                    n    = s[M:1];
                    n[0] = n[0] | s[0];
                    e    = e + 1;
                end else begin
                    lz = 0;
                    for (int i = 0; i < M; i++)
                        if (s[i]) lz = M - 1 - i;
                    n = s[M-1:0] << lz;
                    e = e - lz;
                end
                rnd = n[2] & (n[1] | n[0] | n[3]);
                fr  = {1'b0, n[M-2:3]} + {{FW{1'b0}}, rnd};
                if (fr[FW]) e = e + 1;
                if (e > (1 << EW) - 1)
                    r = {2'b10, sr, {(BITWIDTH-1){1'b0}}};
                else if (e < 0)
                    r = '0;
                else
                    r = {2'b01, sr, e[EW-1:0], fr[FW-1:0]};
            end
        end
        return r;
    endfunction

    logic [W-1:0]  sum    [CHANNELS];
    logic          p_vld  [L];
    logic [CW-1:0] p_chan [L];
    logic          p_last [L];
    logic [W-1:0]  p_data [L];
    logic          rdy_en;
    logic [W-1:0]  cur_sum, add_res;
    logic          chan_ok, hazard, last_inflight, out_block, stall, accept, wb;

    // Read the addressed channel sum; out-of-range channels read as zero
    always_comb begin
        cur_sum = '0;
        for (int c = 0; c < CHANNELS; c++)
            if (bus.in_chan == CW'(c)) cur_sum = sum[c];
    end

    // Scan in-flight stages for same-channel RAW hazards and pending lasts
    always_comb begin
        hazard        = 1'b0;
        last_inflight = 1'b0;
        for (int k = 0; k < L; k++) begin
            if (p_vld[k] && p_chan[k] == bus.in_chan) hazard = 1'b1;
            if (p_vld[k] && p_last[k]) last_inflight = 1'b1;
        end
    end

    assign chan_ok   = int'(bus.in_chan) < CHANNELS;
    assign add_res   = fp_add(cur_sum, bus.in_data);
    assign out_block = bus.out_valid && !bus.out_ready && last_inflight;
    // A last can be issued while the output register is still occupied; if it
    // reaches writeback before the consumer reads, the whole pipeline freezes
    // rather than drop either result. New issue is already blocked by out_block.
    assign stall     = p_vld[L-1] && p_last[L-1] && bus.out_valid && !bus.out_ready;
    assign wb        = p_vld[L-1] && !stall;
    assign bus.in_ready = rdy_en && !clear && !hazard && !out_block;
    assign accept    = bus.in_valid && bus.in_ready;

    // Ready enable: held low during reset, opens on the first edge after release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdy_en <= 1'b0;
        else     rdy_en <= 1'b1;
    end

    // Adder result pipeline carrying valid/channel/last alongside the sum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < L; k++) begin
                p_vld[k]  <= 1'b0;
                p_chan[k] <= '0;
                p_last[k] <= 1'b0;
                p_data[k] <= '0;
            end
        end else if (clear) begin
            for (int k = 0; k < L; k++) p_vld[k] <= 1'b0;
        end else if (!stall) begin
            p_vld[0]  <= accept && chan_ok;
            p_chan[0] <= bus.in_chan;
            p_last[0] <= bus.in_last;
            p_data[0] <= add_res;
            for (int k = 1; k < L; k++) begin
                p_vld[k]  <= p_vld[k-1];
                p_chan[k] <= p_chan[k-1];
                p_last[k] <= p_last[k-1];
                p_data[k] <= p_data[k-1];
            end
        end
    end

    // Channel sums: writeback of partial result, or zero after a final term
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) sum[c] <= '0;
        end else if (clear) begin
            for (int c = 0; c < CHANNELS; c++) sum[c] <= '0;
        end else if (wb) begin
            for (int c = 0; c < CHANNELS; c++)
                if (p_chan[L-1] == CW'(c)) sum[c] <= p_last[L-1] ? '0 : p_data[L-1];
        end
    end

    // Output register: loads finished sums, frees when the consumer reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_chan  <= '0;
            bus.out_data  <= '0;
        end else if (clear) begin
            bus.out_valid <= 1'b0;
        end else if (wb && p_last[L-1]) begin
            bus.out_valid <= 1'b1;
            bus.out_chan  <= p_chan[L-1];
            bus.out_data  <= p_data[L-1];
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fp_accum_bank.sv
// tb/tb_fp_accum_bank.sv - directed self-checking bench for fp_accum_bank
module tb_fp_accum_bank;
    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic clear = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   w, n, tot;

    fp_accum_bank_if #(.W(18), .CW(2)) bus ();

    fp_accum_bank #(.BITWIDTH(16), .CHANNELS(3), .ADD_LAT(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [1:0] ch, input logic [17:0] d);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_chan"},  32'(bus.out_chan),  32'(ch));
        chk({tag, "_data"},  32'(bus.out_data),  32'(d));
    endtask

    task automatic send(input logic [1:0] ch, input logic [17:0] d, input logic lst, output int waited);
        bus.in_valid = 1'b1;
        bus.in_chan  = ch;
        bus.in_data  = d;
        bus.in_last  = lst;
        #1;
        waited = 0;
        while (!bus.in_ready && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("send_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_out(output int cycles);
        cycles = 0;
        while (!bus.out_valid && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic pop();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic two_term(input string tag, input logic [1:0] ch, input logic [17:0] a,
                            input logic [17:0] b, input logic [17:0] e);
        int ww, nn;
        send(ch, a, 1'b0, ww);
        send(ch, b, 1'b1, ww);
        wait_out(nn);
        chk_out(tag, ch, e);
        pop();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_chan   = '0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        #2 rst = 1'b1;
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1 chk("ready_before_first_edge", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        chk("ready_after_release", 32'(bus.in_ready), 32'd1);

        // 1.0 + 2.0 on ch0, same-channel hazard spacing, writeback latency
        send(2'd0, 18'h13C00, 1'b0, w);
        chk("t1_first_wait", 32'(w), 32'd0);
        send(2'd0, 18'h14000, 1'b1, w);
        chk("t1_hazard_wait", 32'(w), 32'd2);
        wait_out(n);
        chk("t1_latency", 32'(n), 32'd2);
        chk_out("t1", 2'd0, 18'h14200);
        pop();
        chk("t1_popped", 32'(bus.out_valid), 32'd0);
        send(2'd0, 18'h13C00, 1'b1, w);
        wait_out(n);
        chk_out("t1_sum_zeroed", 2'd0, 18'h13C00);
        pop();

        // Alternating ch0/ch1, four 1.0 terms each, consumer held off
        tot = 0;
        for (int i = 0; i < 4; i++) begin
            send(2'd0, 18'h13C00, i == 3, w);
            tot += w;
            send(2'd1, 18'h13C00, i == 3, w);
            tot += w;
        end
        chk("t2_stall_cycles", 32'(tot), 32'd3);
        wait_out(n);
        chk_out("t2_ch0", 2'd0, 18'h14400);
        bus.in_chan = 2'd2;
        repeat (3) begin @(posedge clk); #1; end
        chk("t2_backpressure_ready", 32'(bus.in_ready), 32'd0);
        chk_out("t2_ch0_stable", 2'd0, 18'h14400);
        pop();
        chk_out("t2_ch1", 2'd1, 18'h14400);
        pop();
        chk("t2_drained", 32'(bus.out_valid), 32'd0);

        // Arithmetic corner cases on ch2
        two_term("sub",          2'd2, 18'h14200, 18'h1BC00, 18'h14000);
        two_term("cancel",       2'd2, 18'h13C00, 18'h1BC00, 18'h00000);
        two_term("inf",          2'd2, 18'h20000, 18'h13C00, 18'h20000);
        two_term("nan",          2'd2, 18'h20000, 18'h28000, 18'h30000);
        two_term("rne_tie_even", 2'd2, 18'h13C00, 18'h11000, 18'h13C00);
        two_term("rne_tie_odd",  2'd2, 18'h13C01, 18'h11000, 18'h13C02);

        // Out-of-range channel is accepted and discarded
        send(2'd3, 18'h13C00, 1'b1, w);
        chk("oor_wait", 32'(w), 32'd0);
        repeat (4) begin @(posedge clk); #1; end
        chk("oor_no_output", 32'(bus.out_valid), 32'd0);

        // Clear with ops in flight and a pending result
        send(2'd1, 18'h13C00, 1'b0, w);
        send(2'd2, 18'h13C00, 1'b1, w);
        wait_out(n);
        chk("clr_pending", 32'(bus.out_valid), 32'd1);
        send(2'd1, 18'h14000, 1'b0, w);
        send(2'd0, 18'h14000, 1'b0, w);
        clear = 1'b1;
        #1 chk("clr_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clr_out_valid", 32'(bus.out_valid), 32'd0);
        repeat (4) begin @(posedge clk); #1; end
        chk("clr_quiet", 32'(bus.out_valid), 32'd0);
        send(2'd2, 18'h13C00, 1'b1, w);
        wait_out(n);
        chk_out("clr_ch2", 2'd2, 18'h13C00);
        pop();
        send(2'd1, 18'h13C00, 1'b1, w);
        wait_out(n);
        chk_out("clr_ch1", 2'd1, 18'h13C00);
        pop();
        send(2'd0, 18'h13C00, 1'b1, w);
        wait_out(n);
        chk_out("clr_ch0", 2'd0, 18'h13C00);
        pop();

        // Asynchronous reset mid-cycle with a pending result
        send(2'd2, 18'h13C00, 1'b0, w);
        send(2'd1, 18'h14000, 1'b1, w);
        wait_out(n);
        chk_out("pre_rst", 2'd1, 18'h14000);
        send(2'd2, 18'h14000, 1'b0, w);
        #3 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_out_chan",  32'(bus.out_chan),  32'd0);
        chk("arst_out_data",  32'(bus.out_data),  32'd0);
        chk("arst_in_ready",  32'(bus.in_ready),  32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        #1 chk("arst_release_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        chk("arst_ready_after_edge", 32'(bus.in_ready), 32'd1);
        send(2'd2, 18'h13C00, 1'b1, w);
        wait_out(n);
        chk_out("post_rst_ch2", 2'd2, 18'h13C00);
        pop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
